camera_capture_ctrl: RTL
========================

// Module: camera_capture_ctrl
// PURPOSE
// Parametrised successor of the DVP camera capture path. Samples the 8-bit camera bus on
// PCLK, packs bytes into WORD_W words and drives a write port of the frame dual-port RAM.
// Adds single-shot/continuous modes, a per-frame word count, frame counter, overflow flag
// and line-end flushing of partial words. Sits between the sensor pins and the frame RAM.
// PARAMETERS
// WORD_W        32   RAM word width; multiple of 8; BPW = WORD_W/8 bytes per word
// ADDR_W        17   RAM word address width
// DEPTH         2**ADDR_W  number of usable words; writes beyond DEPTH-1 are dropped
// BYTES_PER_PIX 2    bytes per pixel (used only by decimation)
// CNT_W         8    FRAME_CNT width; wraps modulo 2**CNT_W
// PORTS
// PCLK        in   1       sole clock (camera pixel clock); all logic on rising edge
// HRESETn     in   1       asynchronous active-low reset
// CAM_DATA    in   8       camera data bus
// VSYNC       in   1       high = vertical blanking
// HREF        in   1       high = valid line bytes
// CAP_REQ     in   1       level capture request (already synchronous to PCLK)
// CONTINUOUS  in   1       1 = capture back-to-back frames; sampled on leaving IDLE
// DATA_READY  out  1       single-shot frame complete; level, held until CAP_REQ low
// FRAME_DONE  out  1       one-cycle pulse per completed frame (both modes)
// CAP_BUSY    out  1       high in any state other than IDLE
// WR_EN       out  1       RAM write strobe
// WR_ADDR     out  ADDR_W  RAM word address
// WR_DATA     out  WORD_W  RAM write data
// WORD_CNT    out  ADDR_W+1  words written in the last completed frame
// FRAME_CNT   out  CNT_W   completed-frame counter
// OVERFLOW    out  1       sticky: a write was dropped in the current/last frame
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, byte index 0, address 0.
// - FSM: IDLE->ARM when CAP_REQ. ARM->SOF when VSYNC=1. SOF->CAPT when VSYNC=0.
//   CAPT->(VSYNC=1): end of frame. If continuous mode and CAP_REQ=1 -> SOF, else
//   single-shot -> DONE, continuous with CAP_REQ=0 -> IDLE. DONE->IDLE when CAP_REQ=0.
//   ARM/SOF->IDLE when CAP_REQ=0. CAP_REQ dropping in CAPT does not abort the frame.
// - Byte capture: qualifier q = CAPT & HREF & ~VSYNC. Each PCLK with q, CAM_DATA is
//   stored at byte lane BPW-1-idx (first byte of a word in the MS lane); idx increments.
// - Word write: when idx reaches BPW-1, the next cycle WR_EN=1 with the full word and
//   current WR_ADDR (latency 1); WR_ADDR increments after the write. Accumulation of the
//   following word continues without stall (separate output register).
// - Flush: q falling (HREF low or VSYNC high) with idx!=0 -> next cycle one write of the
//   partial word, unfilled lanes zero; idx clears. idx always clears when q=0.
// - Address/overflow: WR_ADDR=0 and OVERFLOW=0 on SOF->CAPT. A write at WR_ADDR=DEPTH-1
//   proceeds; further writes in the frame are suppressed (WR_EN=0), WR_ADDR saturates,
//   OVERFLOW=1 until the next SOF->CAPT.
// - End of frame (CAPT with VSYNC=1): FRAME_DONE pulses the cycle after any final flush
//   write; WORD_CNT latched with writes performed (max DEPTH); FRAME_CNT+1, wraps.
// - DATA_READY=1 exactly while in DONE.
// - Reset mid-frame: immediate return to reset values; no partial write emitted.
// CONFIGURATION
// CAMERA_DECIM_EN: adds input DECIM (1 bit, sampled on SOF->CAPT). When DECIM=1 only
//   even lines (line counter from 0 at frame start, +1 on HREF falling) and even pixels
//   (groups of BYTES_PER_PIX bytes, counter reset per line) feed byte capture; odd ones
//   are ignored, halving each dimension. DECIM=0 or macro undefined: every byte captured,
//   port DECIM absent.
// TESTING
// - Single shot, WORD_W=32: 1 line of 8 bytes 01..08 -> 2 writes: addr0=0x01020304,
//   addr1=0x05060708; FRAME_DONE pulse; WORD_CNT=2; DATA_READY high until CAP_REQ=0.
// - Partial word: line of 6 bytes AA..FF -> addr0=0xAABBCCDD, addr1=0xEEFF0000 written
//   the cycle after HREF falls.
// - Continuous: 3 frames of 2 lines x 4 bytes, CAP_REQ dropped in frame 3 -> FRAME_CNT=3,
//   each frame starts at addr0, WORD_CNT=2, IDLE after frame 3, DATA_READY never set.
// - Overflow: DEPTH=4, frame of 24 bytes -> writes at addr0..3 only, OVERFLOW=1,
//   WORD_CNT=4; next frame clears OVERFLOW at SOF->CAPT.
// - Request abort/reset: CAP_REQ low in SOF -> IDLE, no writes; HRESETn low mid-line ->
//   all outputs 0 next edge, no write emitted.
// - CAMERA_DECIM_EN, DECIM=1, BYTES_PER_PIX=2: 4 lines x 8 bytes -> lines 0,2 keep bytes
//   0,1,4,5 -> 2 words total; DECIM=0 -> 8 words.

Source files
------------

// File: rtl/camera_capture_ctrl.sv
// DVP camera capture: packs PCLK-sampled bytes into WORD_W words for the frame RAM write port.
// Define CAMERA_DECIM_EN to add the DECIM input (2:1 line and pixel decimation).
module camera_capture_ctrl #(
    parameter int WORD_W        = 32,
    parameter int ADDR_W        = 17,
    parameter int DEPTH         = 2**ADDR_W,
    parameter int BYTES_PER_PIX = 2,
    parameter int CNT_W         = 8
) (
    input  logic                PCLK,
    input  logic                HRESETn,
    input  logic [7:0]          CAM_DATA,
    input  logic                VSYNC,
    input  logic                HREF,
    input  logic                CAP_REQ,
    input  logic                CONTINUOUS,
`ifdef CAMERA_DECIM_EN
    input  logic                DECIM,
`endif
    output logic                DATA_READY,
    output logic                FRAME_DONE,
    output logic                CAP_BUSY,
    output logic                WR_EN,
    output logic [ADDR_W-1:0]   WR_ADDR,
    output logic [WORD_W-1:0]   WR_DATA,
    output logic [ADDR_W:0]     WORD_CNT,
    output logic [CNT_W-1:0]    FRAME_CNT,
    output logic                OVERFLOW
);
    localparam int BPW    = WORD_W / 8;
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int STAGES = 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ARM, SOF, CAPT, DONE} state_t;
    state_t state, state_nxt;

    logic                  cont_r;
    logic                  q_raw, keep, cap, idx_last, wr_req, blocked, sof_go, eof, full;
    logic [IDX_W-1:0]      idx;
    logic [BPW-1:0][7:0]   acc, acc_nxt;
    logic [WORD_W-1:0]     wr_word;
    logic [ADDR_W:0]       wcnt;
    logic [STAGES:0]       vld_pipe;

    // ---------------- control FSM ----------------
    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= IDLE;
            cont_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && CAP_REQ)
                cont_r <= CONTINUOUS;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (CAP_REQ) state_nxt = ARM;
            ARM:  if (!CAP_REQ) state_nxt = IDLE;
                  else if (VSYNC) state_nxt = SOF;
            SOF:  if (!CAP_REQ) state_nxt = IDLE;
                  else if (!VSYNC) state_nxt = CAPT;
            // a dropped request only ends continuous capture at the frame boundary
            CAPT: if (VSYNC) state_nxt = !cont_r ? DONE : (CAP_REQ ? SOF : IDLE);
            DONE: if (!CAP_REQ) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sof_go     = (state == SOF) && (state_nxt == CAPT);
    assign eof        = (state == CAPT) && VSYNC;
    assign DATA_READY = (state == DONE);
    assign CAP_BUSY   = (state != IDLE);

    // ---------------- optional decimation ----------------
`ifdef CAMERA_DECIM_EN
    localparam int PB_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    logic            decim_r, line_odd, pix_odd, href_d;
    logic [PB_W-1:0] pix_byte;

    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            decim_r  <= 1'b0;
            line_odd <= 1'b0;
            pix_odd  <= 1'b0;
            href_d   <= 1'b0;
            pix_byte <= '0;
        end else if (sof_go) begin
            decim_r  <= DECIM;
            line_odd <= 1'b0;
            pix_odd  <= 1'b0;
            href_d   <= 1'b0;
            pix_byte <= '0;
        end else begin
            href_d <= HREF;
            if (state == CAPT && href_d && !HREF)
                line_odd <= ~line_odd;
            if (q_raw) begin
                if (pix_byte == PB_W'(BYTES_PER_PIX - 1)) begin
                    pix_byte <= '0;
                    pix_odd  <= ~pix_odd;
                end else begin
                    pix_byte <= pix_byte + PB_W'(1);
                end
            end else begin
                pix_byte <= '0;
                pix_odd  <= 1'b0;
            end
        end
    end

    assign keep = ~decim_r | (~line_odd & ~pix_odd);
`else
    // pixel size only matters when decimating
    assign keep = (BYTES_PER_PIX > 0);
`endif

    // ---------------- byte packing ----------------
    // Line-end flush follows the raw qualifier so skipped pixels never split a word.
    assign q_raw    = (state == CAPT) && HREF && !VSYNC;
    assign cap      = q_raw && keep;
    assign idx_last = (idx == IDX_W'(BPW - 1));

    always_comb begin
        acc_nxt = acc;
        for (int l = 0; l < BPW; l++)
            if (idx == IDX_W'(BPW - 1 - l))
                acc_nxt[l] = CAM_DATA;
    end

    assign wr_req  = (cap && idx_last) || (!q_raw && idx != '0);
    assign wr_word = cap ? acc_nxt : acc;
    assign blocked = full || (WR_EN && WR_ADDR == LAST_ADDR);

    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx      <= '0;
            acc      <= '0;
            WR_EN    <= 1'b0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
            full     <= 1'b0;
            OVERFLOW <= 1'b0;
            wcnt     <= '0;
        end else begin
            WR_EN <= 1'b0;
            if (cap) begin
                if (idx_last) begin
                    acc <= '0;
                    idx <= '0;
                end else begin
                    acc <= acc_nxt;
                    idx <= idx + IDX_W'(1);
                end
            end else if (!q_raw) begin
                acc <= '0;
                idx <= '0;
            end

            if (sof_go) begin
                WR_ADDR  <= '0;
                full     <= 1'b0;
                OVERFLOW <= 1'b0;
                wcnt     <= '0;
            end else begin
                // address advances after the write; the last word pins it
                if (WR_EN) begin
                    if (WR_ADDR == LAST_ADDR)
                        full <= 1'b1;
                    else
                        WR_ADDR <= WR_ADDR + ADDR_W'(1);
                end
                if (wr_req) begin
                    if (blocked) begin
                        OVERFLOW <= 1'b1;
                    end else begin
                        WR_EN   <= 1'b1;
                        WR_DATA <= wr_word;
                        wcnt    <= wcnt + (ADDR_W + 1)'(1);
                    end
                end
            end
        end
    end

    // ---------------- frame completion ----------------
    // one extra stage lets a flush issued on the end-of-frame edge land first
    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_pipe  <= '0;
            WORD_CNT  <= '0;
            FRAME_CNT <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], eof};
            if (vld_pipe[0]) begin
                WORD_CNT  <= wcnt;
                FRAME_CNT <= FRAME_CNT + CNT_W'(1);
            end
        end
    end

    assign FRAME_DONE = vld_pipe[STAGES];

endmodule
